// File: rtl/prng_req_arbiter.sv
// Shares one PRNG core among NREQ requesters: seeds and warms it up, then hands
// each prng_done-qualified sample to one requester per cycle in round-robin order.
module prng_req_arbiter #(
    parameter int unsigned   N            = 8,
    parameter int unsigned   NREQ         = 4,
    parameter logic [N-1:0]  SEED_DEFAULT = 8'd42,
    parameter int unsigned   WARMUP       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_seed_valid,
    input  logic [N-1:0]    cfg_seed_data,
    output logic            busy,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            rsp_valid,
    output logic [N-1:0]    rsp_data,
    output logic            prng_load_seed,
    output logic [N-1:0]    prng_seed_data,
    input  logic [N-1:0]    prng_data,
    input  logic            prng_done,
    output logic [15:0]     sample_cnt
);

    // state  | meaning
    // SEED   | drive load_seed with seed_reg for one cycle
    // WARMUP | discard WARMUP prng_done-qualified samples
    // SERVE  | grant samples round-robin to requesters
    typedef enum logic [1:0] {SEED, WARM, SERVE} state_t;

    localparam int unsigned RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WCW = $clog2(WARMUP + 1);

    state_t            state, state_nxt;
    logic [N-1:0]      seed_reg, seed_reg_nxt;
    logic [RRW-1:0]    rr_ptr, rr_ptr_nxt;
    logic [WCW-1:0]    warm_cnt, warm_cnt_nxt;
    logic              busy_nxt, load_nxt;
    logic [N-1:0]      seed_out_nxt, rsp_data_nxt;
    logic [NREQ-1:0]   gnt_nxt;
    logic [15:0]       cnt_nxt;
    logic              found;
    logic [RRW-1:0]    pick;
    int                idx;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int off = 1; off <= int'(NREQ); off++) begin
            idx = (int'(rr_ptr) + off) % int'(NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = RRW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        seed_reg_nxt = seed_reg;
        rr_ptr_nxt   = rr_ptr;
        warm_cnt_nxt = warm_cnt;
        busy_nxt     = busy;
        load_nxt     = 1'b0;
        seed_out_nxt = prng_seed_data;
        rsp_data_nxt = rsp_data;
        gnt_nxt      = '0;
        cnt_nxt      = sample_cnt;
        if (cfg_seed_valid) begin
            seed_reg_nxt = (cfg_seed_data == '0) ? SEED_DEFAULT : cfg_seed_data;
            state_nxt    = SEED;
            busy_nxt     = 1'b1;
            warm_cnt_nxt = '0;
        end else begin
            case (state)
                SEED: begin
                    load_nxt     = 1'b1;
                    seed_out_nxt = seed_reg;
                    state_nxt    = WARM;
                    warm_cnt_nxt = '0;
                end
                WARM: begin
                    if (prng_done) begin
                        if (warm_cnt == WCW'(WARMUP - 1)) begin
                            state_nxt    = SERVE;
                            busy_nxt     = 1'b0;
                            warm_cnt_nxt = '0;
                        end else begin
                            warm_cnt_nxt = warm_cnt + 1'b1;
                        end
                    end
                end
                SERVE: begin
                    if (prng_done && found) begin
                        gnt_nxt[pick] = 1'b1;
                        rsp_data_nxt  = prng_data;
                        rr_ptr_nxt    = pick;
                        cnt_nxt       = sample_cnt + 16'd1;
                    end
                end
                default: state_nxt = SEED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= SEED;
            seed_reg       <= SEED_DEFAULT;
            rr_ptr         <= RRW'(NREQ - 1);
            warm_cnt       <= '0;
            busy           <= 1'b1;
            prng_load_seed <= 1'b0;
            prng_seed_data <= '0;
            rsp_data       <= '0;
            gnt            <= '0;
            rsp_valid      <= 1'b0;
            sample_cnt     <= '0;
        end else begin
            state          <= state_nxt;
            seed_reg       <= seed_reg_nxt;
            rr_ptr         <= rr_ptr_nxt;
            warm_cnt       <= warm_cnt_nxt;
            busy           <= busy_nxt;
            prng_load_seed <= load_nxt;
            prng_seed_data <= seed_out_nxt;
            rsp_data       <= rsp_data_nxt;
            gnt            <= gnt_nxt;
            rsp_valid      <= |gnt_nxt;
            sample_cnt     <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_prng_req_arbiter.sv
// Self-checking bench for prng_req_arbiter: vector table, directed corner cases,
// and randomized traffic against a behavioural reference model.
module tb_prng_req_arbiter;

    localparam int NREQ = 4;
    localparam int WARMUP = 4;
    localparam logic [7:0] SEED_DEF = 8'd42;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_seed_valid;
    logic [7:0] cfg_seed_data;
    logic       busy;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       prng_load_seed;
    logic [7:0] prng_seed_data;
    logic [7:0] prng_data;
    logic       prng_done;
    logic [15:0] sample_cnt;

    int tests = 0;
    int fails = 0;

    prng_req_arbiter dut (
        .clk(clk), .reset(reset),
        .cfg_seed_valid(cfg_seed_valid), .cfg_seed_data(cfg_seed_data),
        .busy(busy), .req(req), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .prng_load_seed(prng_load_seed), .prng_seed_data(prng_seed_data),
        .prng_data(prng_data), .prng_done(prng_done), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = loading seed, 1 = warming up, 2 = serving.
    int          m_phase;
    int          m_left;
    int          m_last;
    logic [7:0]  m_seed, m_seed_out, m_rsp;
    logic        m_busy, m_load;
    logic [3:0]  m_gnt;
    logic [15:0] m_cnt;

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_last = NREQ - 1;
        m_seed = SEED_DEF; m_seed_out = 8'd0; m_rsp = 8'd0;
        m_busy = 1'b1; m_load = 1'b0; m_gnt = 4'd0; m_cnt = 16'd0;
    endtask

    task automatic model_edge();
        int best, best_rank, rank;
        if (reset) begin
            model_reset();
            return;
        end
        m_load = 1'b0;
        m_gnt  = 4'd0;
        if (cfg_seed_valid) begin
            m_seed  = (cfg_seed_data == 8'd0) ? SEED_DEF : cfg_seed_data;
            m_phase = 0;
            m_busy  = 1'b1;
            return;
        end
        if (m_phase == 0) begin
            m_load = 1'b1; m_seed_out = m_seed; m_phase = 1; m_left = WARMUP;
        end else if (m_phase == 1) begin
            if (prng_done) begin
                m_left--;
                if (m_left == 0) begin m_phase = 2; m_busy = 1'b0; end
            end
        end else if (prng_done && req != 4'd0) begin
            best = 0; best_rank = NREQ;
            for (int i = 0; i < NREQ; i++) begin
                rank = (i - m_last - 1 + 2 * NREQ) % NREQ;
                if (req[i] && rank < best_rank) begin best = i; best_rank = rank; end
            end
            m_gnt = 4'(1 << best);
            m_rsp = prng_data;
            m_last = best;
            m_cnt = m_cnt + 16'd1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model", {gnt, 3'd0, rsp_valid, rsp_data, 3'd0, prng_load_seed,
                      prng_seed_data, 3'd0, busy, sample_cnt},
                     {m_gnt, 3'd0, |m_gnt, m_rsp, 3'd0, m_load,
                      m_seed_out, 3'd0, m_busy, m_cnt});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
        cfg_seed_valid = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic        done;
        logic [3:0]  exp_gnt;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[14];
    logic [7:0] prev_data;

    initial begin
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 16'd1};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 16'd2};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 16'd3};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 16'd4};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 16'd5};
        vecs[5]  = '{4'b0100, 1'b1, 4'b0100, 16'd6};
        vecs[6]  = '{4'b0100, 1'b1, 4'b0100, 16'd7};
        vecs[7]  = '{4'b0101, 1'b1, 4'b0001, 16'd8};
        vecs[8]  = '{4'b0101, 1'b1, 4'b0100, 16'd9};
        vecs[9]  = '{4'b0101, 1'b1, 4'b0001, 16'd10};
        vecs[10] = '{4'b0000, 1'b1, 4'b0000, 16'd10};
        vecs[11] = '{4'b1111, 1'b0, 4'b0000, 16'd10};
        vecs[12] = '{4'b1111, 1'b0, 4'b0000, 16'd10};
        vecs[13] = '{4'b1111, 1'b0, 4'b0000, 16'd10};

        reset = 1'b1; cfg_seed_valid = 1'b0; cfg_seed_data = 8'd0;
        req = 4'd0; prng_data = 8'd0; prng_done = 1'b0;
        model_reset();
        #1;
        check_model();
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Startup: one-cycle seed load with the default seed, busy until warm-up done.
        reset = 1'b0; prng_done = 1'b1; req = 4'b1111;
        step();
        chk("load_first", {prng_load_seed, prng_seed_data}, {1'b1, 8'd42});
        for (int i = 1; i <= 4; i++) begin
            prng_data = 8'($urandom);
            step();
            chk("load_single", prng_load_seed, 1'b0);
            chk("busy_startup", busy, (i < 4) ? 1'b1 : 1'b0);
            chk("no_gnt_warm", gnt, 4'd0);
        end

        // Vector table: round-robin rotation, single requester, pairs, stall.
        foreach (vecs[i]) begin
            req = vecs[i].req; prng_done = vecs[i].done;
            prng_data = 8'($urandom); prev_data = prng_data;
            step();
            chk("vec_gnt", gnt, vecs[i].exp_gnt);
            chk("vec_cnt", sample_cnt, vecs[i].exp_cnt);
            if (vecs[i].exp_gnt != 4'd0) chk("vec_data", rsp_data, prev_data);
        end

        // Reseed while serving; last grant went to requester 0.
        req = 4'b1111; prng_done = 1'b1;
        cfg_seed_valid = 1'b1; cfg_seed_data = 8'h5A;
        for (int i = 0; i <= 6; i++) begin
            prng_data = 8'($urandom);
            step();
            if (i == 1) chk("reseed_load", {prng_load_seed, prng_seed_data}, {1'b1, 8'h5A});
            chk("reseed_busy", busy, (i < 5) ? 1'b1 : 1'b0);
            chk("reseed_gnt", gnt, (i == 6) ? 4'b0010 : 4'b0000);
        end

        // Zero seed substitutes the default; prng_done low stalls warm-up.
        cfg_seed_valid = 1'b1; cfg_seed_data = 8'h00;
        step();
        step();
        chk("zero_seed", {prng_load_seed, prng_seed_data}, {1'b1, 8'd42});
        prng_done = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); chk("warm_stall", busy, 1'b1); end
        prng_done = 1'b1;
        for (int i = 1; i <= 4; i++) begin step(); chk("warm_resume", busy, (i < 4) ? 1'b1 : 1'b0); end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            req = 4'($urandom);
            prng_done = ($urandom_range(0, 3) != 0);
            prng_data = 8'($urandom);
            cfg_seed_valid = ($urandom_range(0, 24) == 0);
            cfg_seed_data = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            step();
        end

        // Asynchronous reset in the middle of warm-up.
        cfg_seed_valid = 1'b1; cfg_seed_data = 8'h33; prng_done = 1'b1;
        step(); step(); step();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_model();
        chk("async_rst", {busy, gnt, rsp_valid, prng_load_seed, sample_cnt},
                         {1'b1, 4'd0, 1'b0, 1'b0, 16'd0});
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("rst_ready", busy, 1'b0);

        // Counter wrap over 65536 grants.
        req = 4'b1111; prng_done = 1'b1;
        for (int i = 1; i <= 65536; i++) begin
            prng_data = 8'(i);
            step();
            if (i == 65535) chk("cnt_max", sample_cnt, 16'hFFFF);
        end
        chk("cnt_wrap", sample_cnt, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
